// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter that shares one synchronous-read single-port memory between
// requesters A and B, and clears every word to INIT_VAL after each reset.
module mem_rr_arbiter #(
  parameter int                ADDR_W   = 3,
  parameter int                DATA_W   = 16,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              init_done,
  output logic              fsm_state
);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            state;
  logic [ADDR_W-1:0] init_cnt;
  logic              rr_b;
  logic              rd_v;
  logic              rd_b;
  logic              run;
  logic              sel_b;

  assign fsm_state = (state == ST_RUN);
  assign run       = rst_n && (state == ST_RUN);

  // Handshake: req acts as valid and gnt as ready; an access transfers in any
  // cycle where both are high, and the requester holds we/addr/wdata until then.
  always_comb begin
    sel_b = 1'b0;
    if (a_req && b_req) sel_b = rr_b;
    else                sel_b = b_req;
  end

  assign a_gnt = run && a_req && !sel_b;
  assign b_gnt = run && b_req && sel_b;

  always_comb begin
    mem_cs   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (rst_n) begin
      if (state == ST_INIT) begin
        mem_cs   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = init_cnt;
        mem_din  = INIT_VAL;
      end else if (a_gnt) begin
        mem_cs   = 1'b1;
        mem_we   = a_we;
        mem_addr = a_addr;
        mem_din  = a_wdata;
      end else if (b_gnt) begin
        mem_cs   = 1'b1;
        mem_we   = b_we;
        mem_addr = b_addr;
        mem_din  = b_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (&init_cnt) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end
        end
        ST_RUN: state <= ST_RUN;
        default: state <= ST_INIT;
      endcase
    end
  end

  // The pointer names whoever lost the last grant; idle cycles leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rr_b <= 1'b0;
    else if (a_gnt) rr_b <= 1'b1;
    else if (b_gnt) rr_b <= 1'b0;
  end

  // Stage 1 (rd_v/rd_b) marks the read the memory answers this cycle; stage 2
  // is the per-requester rvalid/rdata registers loaded from mem_dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v     <= 1'b0;
      rd_b     <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      rd_v     <= (a_gnt && !a_we) || (b_gnt && !b_we);
      rd_b     <= b_gnt;
      a_rvalid <= rd_v && !rd_b;
      b_rvalid <= rd_v && rd_b;
      if (rd_v && !rd_b) a_rdata <= mem_dout;
      if (rd_v && rd_b)  b_rdata <= mem_dout;
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: directed scenarios plus random traffic, with a
// behavioural memory and a reference model kept alongside the DUT.
module tb_mem_rr_arbiter;
  localparam int AW = 3;
  localparam int DW = 16;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          mem_cs, mem_we, init_done, fsm_state;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mem_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .INIT_VAL('0)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .init_done(init_done), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // behavioural single-port memory, synchronous read
  logic [DW-1:0] mem_arr [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem_arr[i] = DW'($urandom);
    mem_dout = DW'($urandom);
  end
  always @(posedge clk)
    if (mem_cs) begin
      if (mem_we) mem_arr[mem_addr] <= mem_din;
      else        mem_dout <= mem_arr[mem_addr];
    end

  // reference model and scoreboard
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_a_q[$], exp_b_q[$];
  int            due_a_q[$], due_b_q[$];
  logic [DW-1:0] hold_a, hold_b;
  int            init_left;
  bit            last_won_b;

  always @(negedge clk) begin
    bit            ea, eb, ev_a, ev_b;
    logic [AW-1:0] sweep_addr;
    logic [DW+AW+1:0] exp_bus;
    if (!rst_n) begin
      init_left = DEPTH;
      last_won_b = 1'b1;
      hold_a = '0;
      hold_b = '0;
      exp_a_q.delete(); exp_b_q.delete(); due_a_q.delete(); due_b_q.delete();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      checks++;
      if ({a_gnt, b_gnt, mem_cs, mem_we, a_rvalid, b_rvalid, init_done} !== 7'b0 ||
          a_rdata !== '0 || b_rdata !== '0 || mem_addr !== '0 || mem_din !== '0) begin
        errors++;
        $display("FAIL sb_reset: gnt=%b%b cs=%b we=%b rv=%b%b done=%b rdata=%h/%h required all zero",
                 a_gnt, b_gnt, mem_cs, mem_we, a_rvalid, b_rvalid, init_done, a_rdata, b_rdata);
      end
    end else begin
      ev_a = due_a_q.size() > 0 && due_a_q[0] == cyc;
      ev_b = due_b_q.size() > 0 && due_b_q[0] == cyc;
      if (ev_a) begin hold_a = exp_a_q.pop_front(); void'(due_a_q.pop_front()); end
      if (ev_b) begin hold_b = exp_b_q.pop_front(); void'(due_b_q.pop_front()); end
      checks++;
      if (a_rvalid !== ev_a || a_rdata !== hold_a) begin
        errors++;
        $display("FAIL sb_a_return @%0d: rvalid=%b rdata=%h required %b %h", cyc, a_rvalid, a_rdata, ev_a, hold_a);
      end
      checks++;
      if (b_rvalid !== ev_b || b_rdata !== hold_b) begin
        errors++;
        $display("FAIL sb_b_return @%0d: rvalid=%b rdata=%h required %b %h", cyc, b_rvalid, b_rdata, ev_b, hold_b);
      end
      if (init_left > 0) begin
        sweep_addr = AW'(DEPTH - init_left);
        checks++;
        if ({mem_cs, mem_we, mem_addr, mem_din, a_gnt, b_gnt, init_done, fsm_state} !==
            {2'b11, sweep_addr, DW'(0), 4'b0000}) begin
          errors++;
          $display("FAIL sb_sweep: cs=%b we=%b addr=%0d din=%h gnt=%b%b done=%b required 1 1 %0d 0000 00 0",
                   mem_cs, mem_we, mem_addr, mem_din, a_gnt, b_gnt, init_done, sweep_addr);
        end
        init_left--;
      end else begin
        // a tie goes to whichever side was not granted most recently
        ea = a_req && (!b_req || last_won_b);
        eb = b_req && !ea;
        if (ea)      exp_bus = {1'b1, a_we, a_addr, a_wdata};
        else if (eb) exp_bus = {1'b1, b_we, b_addr, b_wdata};
        else         exp_bus = '0;
        checks++;
        if (a_gnt !== ea || b_gnt !== eb || init_done !== 1'b1 || fsm_state !== 1'b1 ||
            {mem_cs, mem_we, mem_addr, mem_din} !== exp_bus) begin
          errors++;
          $display("FAIL sb_arb @%0d: gnt=%b%b done=%b bus=%h required gnt=%b%b done=1 bus=%h",
                   cyc, a_gnt, b_gnt, init_done, {mem_cs, mem_we, mem_addr, mem_din}, ea, eb, exp_bus);
        end
        if (ea) begin
          last_won_b = 1'b0;
          if (a_we) ref_mem[a_addr] = a_wdata;
          else begin exp_a_q.push_back(ref_mem[a_addr]); due_a_q.push_back(cyc + 2); end
        end else if (eb) begin
          last_won_b = 1'b1;
          if (b_we) ref_mem[b_addr] = b_wdata;
          else begin exp_b_q.push_back(ref_mem[b_addr]); due_b_q.push_back(cyc + 2); end
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    a_req = 1'b1; a_addr = 3'd1;
    b_req = 1'b1; b_addr = 3'd6;
    @(negedge clk);
    checks++;
    if ({a_gnt, b_gnt, mem_cs, init_done, a_rvalid, b_rvalid} !== 6'b0 || a_rdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b%b cs=%b done=%b rv=%b%b rdata=%h required zeros",
               a_gnt, b_gnt, mem_cs, init_done, a_rvalid, b_rvalid, a_rdata);
    end
    tick();
  endtask

  task automatic test_init();
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== AW'(i) || mem_din !== '0 || a_gnt !== 1'b0 || b_gnt !== 1'b0) begin
        errors++;
        $display("FAIL init_sweep[%0d]: we=%b addr=%0d din=%h gnt=%b%b required 1 %0d 0000 00",
                 i, mem_we, mem_addr, mem_din, a_gnt, b_gnt, i);
      end
      tick();
    end
  endtask

  task automatic test_contention();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (init_done !== 1'b1 || a_gnt !== (k % 2 == 0) || b_gnt !== (k % 2 == 1)) begin
        errors++;
        $display("FAIL contention_gnt[%0d]: done=%b gnt=%b%b required done=1 a=%0d b=%0d",
                 k, init_done, a_gnt, b_gnt, k % 2 == 0, k % 2 == 1);
      end
      if (k >= 2) begin
        checks++;
        if (a_rvalid !== (k % 2 == 0) || b_rvalid !== (k % 2 == 1) || a_rdata !== '0 || b_rdata !== '0) begin
          errors++;
          $display("FAIL contention_ret[%0d]: rv=%b%b rdata=%h/%h required a=%0d b=%0d data 0",
                   k, a_rvalid, b_rvalid, a_rdata, b_rdata, k % 2 == 0, k % 2 == 1);
        end
      end
      tick();
    end
    idle_inputs();
    repeat (3) tick();
  endtask

  task automatic test_write_read();
    a_req = 1'b1; a_we = 1'b1; a_addr = 3'd5; a_wdata = 16'hBEEF;
    @(negedge clk);
    checks++;
    if (a_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 3'd5 || mem_din !== 16'hBEEF) begin
      errors++;
      $display("FAIL wr_issue: gnt=%b we=%b addr=%0d din=%h required 1 1 5 beef", a_gnt, mem_we, mem_addr, mem_din);
    end
    tick();
    a_we = 1'b0;
    @(negedge clk);
    checks++;
    if (a_gnt !== 1'b1 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL rd_issue: gnt=%b we=%b required 1 0", a_gnt, mem_we);
    end
    tick();
    a_req = 1'b0;
    @(negedge clk);
    checks++;
    if (a_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rd_early: a_rvalid=%b required 0", a_rvalid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (a_rvalid !== 1'b1 || a_rdata !== 16'hBEEF || b_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rd_return: a_rvalid=%b a_rdata=%h b_rvalid=%b required 1 beef 0", a_rvalid, a_rdata, b_rvalid);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [4] = '{3'd2, 3'd3, 3'd3, 3'd2};
    logic [DW-1:0] datas [2] = '{16'h2222, 16'h1111};
    for (int i = 0; i < 4; i++) begin
      b_req = 1'b1; b_we = (i < 2); b_addr = addrs[i]; b_wdata = (i == 0) ? 16'h1111 : 16'h2222;
      @(negedge clk);
      tick();
    end
    b_req = 1'b0; b_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (b_rvalid !== (i < 2) || (i < 2 && b_rdata !== datas[i])) begin
        errors++;
        $display("FAIL b2b_return[%0d]: b_rvalid=%b b_rdata=%h required %0d %h",
                 i, b_rvalid, b_rdata, i < 2, (i < 2) ? datas[i] : b_rdata);
      end
      tick();
    end
  endtask

  task automatic test_same_addr();
    a_req = 1'b1; a_we = 1'b1; a_addr = 3'd7; a_wdata = 16'hA5A5;
    @(negedge clk);
    tick();
    idle_inputs();
    b_req = 1'b1; b_we = 1'b0; b_addr = 3'd7;
    @(negedge clk);
    checks++;
    if (b_gnt !== 1'b1) begin
      errors++;
      $display("FAIL raw_gnt: b_gnt=%b required 1", b_gnt);
    end
    tick();
    b_req = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (b_rvalid !== 1'b1 || b_rdata !== 16'hA5A5) begin
      errors++;
      $display("FAIL raw_data: b_rvalid=%b b_rdata=%h required 1 a5a5", b_rvalid, b_rdata);
    end
    tick();
  endtask

  task automatic test_random(input int n);
    bit a_done = 1'b1;
    bit b_done = 1'b1;
    for (int c = 0; c < n; c++) begin
      if (a_done || !a_req || $urandom_range(0, 7) == 0) begin
        a_req = ($urandom_range(0, 3) != 0); a_we = 1'($urandom_range(0, 1));
        a_addr = AW'($urandom_range(0, DEPTH - 1)); a_wdata = DW'($urandom);
      end
      if (b_done || !b_req || $urandom_range(0, 7) == 0) begin
        b_req = ($urandom_range(0, 3) != 0); b_we = 1'($urandom_range(0, 1));
        b_addr = AW'($urandom_range(0, DEPTH - 1)); b_wdata = DW'($urandom);
      end
      @(negedge clk);
      a_done = a_gnt;
      b_done = b_gnt;
      tick();
    end
    idle_inputs();
    repeat (3) tick();
    checks++;
    if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
      errors++;
      $display("FAIL random_drain: outstanding a=%0d b=%0d required 0 0", exp_a_q.size(), exp_b_q.size());
    end
  endtask

  task automatic test_reset_mid_read();
    a_req = 1'b1; a_we = 1'b1; a_addr = 3'd7; a_wdata = 16'h5A5A;
    @(negedge clk);
    tick();
    a_we = 1'b0;
    @(negedge clk);
    checks++;
    if (a_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rst_rd_gnt: a_gnt=%b required 1", a_gnt);
    end
    tick();
    idle_inputs();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (a_rvalid !== 1'b0 || a_rdata !== '0) begin
        errors++;
        $display("FAIL rst_flush[%0d]: a_rvalid=%b a_rdata=%h required 0 0000", i, a_rvalid, a_rdata);
      end
      tick();
    end
    rst_n = 1'b1;
    repeat (DEPTH) tick();
    a_req = 1'b1; a_we = 1'b0; a_addr = 3'd7;
    @(negedge clk);
    checks++;
    if (a_gnt !== 1'b1 || init_done !== 1'b1) begin
      errors++;
      $display("FAIL rst_rerun_gnt: a_gnt=%b init_done=%b required 1 1", a_gnt, init_done);
    end
    tick();
    a_req = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (a_rvalid !== 1'b1 || a_rdata !== 16'h0000) begin
      errors++;
      $display("FAIL rst_rerun_data: a_rvalid=%b a_rdata=%h required 1 0000", a_rvalid, a_rdata);
    end
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_init();
    test_contention();
    test_write_read();
    test_back_to_back();
    test_same_addr();
    test_random(400);
    test_reset_mid_read();
    test_random(200);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
